// File: rtl/hex7seg_mux.sv
// Time-multiplexed hex seven-segment driver: shadowed display contents,
// BLANK/SHOW digit scan with dark gaps, registered polarity-adjusted outputs.
module hex7seg_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    lzb_i,
  input  logic                    load_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      SHOW_TC  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      BLANK_TC = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  // Display contents, bit0 = A ... bit6 = G, active-high.
  function automatic logic [6:0] font(input logic [3:0] nib);
    case (nib)
      4'h0: font = 7'h3F;
      4'h1: font = 7'h06;
      4'h2: font = 7'h5B;
      4'h3: font = 7'h4F;
      4'h4: font = 7'h66;
      4'h5: font = 7'h6D;
      4'h6: font = 7'h7D;
      4'h7: font = 7'h07;
      4'h8: font = 7'h7F;
      4'h9: font = 7'h6F;
      4'hA: font = 7'h77;
      4'hB: font = 7'h7C;
      4'hC: font = 7'h39;
      4'hD: font = 7'h5E;
      4'hE: font = 7'h79;
      default: font = 7'h71;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_en;
  logic                    r_lzb;

  state_t                  r_state, w_state_nxt;
  logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;

  logic [NUM_DIGITS-1:0]   w_vis;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic [3:0]              w_nib;
  logic                    w_dp_sel;
  logic                    w_vis_sel;
  logic                    w_lit;

  logic [6:0]              r_seg;
  logic                    r_dp_o;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame;

  // NOTE: the shadow is a handful of flops, not a memory, so it is reset
  // explicitly; a display must come up dark, not showing power-on garbage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_value <= '0;
      r_dp    <= '0;
      r_en    <= '0;
      r_lzb   <= 1'b0;
    end else if (load_i) begin
      r_value <= value_i;
      r_dp    <= dp_i;
      r_en    <= digit_en_i;
      r_lzb   <= lzb_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= IDX_LAST;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case leaves a variable unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_TC) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end
      end
      default: begin
        if (r_cnt == SHOW_TC) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  // A digit is visible when enabled and not swallowed by leading-zero blanking.
  always_comb begin
    logic zero_run;
    w_vis    = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (r_value[4*i +: 4] == 4'h0);
      w_vis[i] = r_en[i] && !(r_lzb && (i != 0) && zero_run);
    end
  end

  always_comb begin
    w_sel     = '0;
    w_nib     = 4'h0;
    w_dp_sel  = 1'b0;
    w_vis_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel[i]  = 1'b1;
        w_nib     = r_value[4*i +: 4];
        w_dp_sel  = r_dp[i];
        w_vis_sel = w_vis[i];
      end
    end
  end

  assign w_lit = (r_state == ST_SHOW) && w_vis_sel;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_an    <= AN_OFF;
      r_seg   <= SEG_OFF;
      r_dp_o  <= ACTIVE_LOW;
      r_frame <= 1'b0;
    end else begin
      r_an    <= (w_lit ? w_sel : '0) ^ AN_OFF;
      r_seg   <= (w_lit ? font(w_nib) : 7'h00) ^ SEG_OFF;
      r_dp_o  <= (w_lit && w_dp_sel) ^ ACTIVE_LOW;
      r_frame <= w_lit && (r_idx == '0) && (r_cnt == '0);
    end
  end

  assign an_o    = r_an;
  assign seg_o   = r_seg;
  assign dp_o    = r_dp_o;
  assign frame_o = r_frame;

endmodule
